// File: rtl/cdc_xfer_arbiter_pkg.sv
// rtl/cdc_xfer_arbiter_pkg.sv - shared types, default widths and round-robin pick for the cdc transfer arbiter
package cdc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } xfer_state_t;

  localparam int DEF_N           = 4;
  localparam int DEF_W           = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT_CYC = 64;
  localparam int MAX_N           = 32;

  // First set bit of req scanning ptr, ptr+1, ... wrapping at n.
  function automatic int rr_pick(input logic [MAX_N-1:0] req, input int ptr, input int n);
    int   idx;
    int   i;
    logic found;
    idx   = 0;
    i     = 0;
    found = 1'b0;
    for (int k = 0; k < MAX_N; k++) begin
      if (k < n && !found) begin
        i = (ptr + k) % n;
        if (req[i]) begin
          idx   = i;
          found = 1'b1;
        end
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/cdc_xfer_arbiter_if.sv
// rtl/cdc_xfer_arbiter_if.sv - requester and clk2-channel signals of the cdc transfer arbiter
interface cdc_xfer_arbiter_if
  import cdc_arb_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
);
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           err;
  logic           busy;
  logic           cdc_req;
  logic [W-1:0]   cdc_data;
  logic           cdc_ack;

  modport slave (
    input  req, req_data, cdc_ack,
    output grant, done, err, busy, cdc_req, cdc_data
  );

  modport master (
    output req, req_data, cdc_ack,
    input  grant, done, err, busy, cdc_req, cdc_data
  );
endinterface

// File: rtl/cdc_xfer_arbiter_sync.sv
// rtl/cdc_xfer_arbiter_sync.sv - multi-flop level synchronizer, async reset to 0
module cdc_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/cdc_xfer_arbiter.sv
// rtl/cdc_xfer_arbiter.sv - round-robin arbiter + 4-phase req/ack sequencer onto one clk1->clk2 channel
// Optional per-phase handshake timeout enabled by CDC_TIMEOUT_EN.
module cdc_xfer_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int W           = DEF_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk1,
  input  logic              rst_n,
  cdc_xfer_arbiter_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  xfer_state_t   state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  done_q, done_d;
  logic          err_q, err_d;
  logic          cdc_req_q, cdc_req_d;
  logic [W-1:0]  data_q, data_d;
  logic          ack_s;
  logic          tmo;
  logic [IW-1:0] pick_idx;

  cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk1),
    .rst_n (rst_n),
    .d_i   (bus.cdc_ack),
    .q_o   (ack_s)
  );

  assign pick_idx = IW'(rr_pick(MAX_N'(bus.req), int'(ptr_q), N));

`ifdef CDC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Fires on the TIMEOUT_CYC-th cycle spent waiting in one phase.
  assign tmo = (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (state_d != state_q || state_q == IDLE) cnt_d = '0;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign tmo = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    done_d    = '0;
    err_d     = 1'b0;
    cdc_req_d = cdc_req_q;
    data_d    = data_q;
    case (state_q)
      IDLE: begin
        // Stale ack and the done cycle both hold off arbitration.
        if (|bus.req && !ack_s && done_q == '0) begin
          state_d   = REQ;
          grant_d   = N'(1) << pick_idx;
          data_d    = bus.req_data[pick_idx*W +: W];
          cdc_req_d = 1'b1;
          ptr_d     = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      REQ: begin
        if (ack_s) begin
          cdc_req_d = 1'b0;
          state_d   = REL;
        end else if (tmo) begin
          err_d     = 1'b1;
          cdc_req_d = 1'b0;
          grant_d   = '0;
          state_d   = IDLE;
        end
      end
      REL: begin
        if (!ack_s) begin
          done_d  = grant_q;
          grant_d = '0;
          state_d = IDLE;
        end else if (tmo) begin
          err_d   = 1'b1;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      cdc_req_q <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cdc_req_q <= cdc_req_d;
      data_q    <= data_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.cdc_req  = cdc_req_q;
  assign bus.cdc_data = data_q;
endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// tb/tb_cdc_xfer_arbiter.sv - directed self-checking bench for cdc_xfer_arbiter (covers CDC_TIMEOUT_EN on or off)
module tb_cdc_xfer_arbiter;
  logic clk1;
  logic rst_n;
  int   total;
  int   bad;

  logic [2:0] ack_sh;
  logic       ack_force;
  logic       ack_en;

  cdc_xfer_arbiter_if #(.N(4), .W(4)) bus ();

  cdc_xfer_arbiter #(.N(4), .W(4), .SYNC_STAGES(2), .TIMEOUT_CYC(64)) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  // clk2-side responder: ack follows cdc_req three clk1 cycles later.
  always @(posedge clk1) begin
    #2;
    if (!rst_n) ack_sh = '0;
    else        ack_sh = {ack_sh[1:0], bus.cdc_req};
  end
  assign bus.cdc_ack = ack_force | (ack_en & ack_sh[2]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    @(negedge clk1);
  endtask

  task automatic do_reset();
    @(negedge clk1);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] exp_g, input logic [3:0] exp_d);
    int n;
    n = 0;
    while (bus.grant == 4'b0 && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_grant"}, bus.grant, exp_g);
    chk({tag, "_data"}, bus.cdc_data, exp_d);
  endtask

  task automatic wait_done(input string tag, input logic [3:0] exp_g);
    int n;
    n = 0;
    while (bus.done == 4'b0 && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, bus.done, exp_g);
    bus.req = bus.req & ~exp_g;
  endtask

  initial begin
    int n;
    int drop_at;
    total        = 0;
    bad          = 0;
    ack_force    = 1'b0;
    ack_en       = 1'b1;
    ack_sh       = '0;
    bus.req      = '0;
    bus.req_data = 16'hCA53;
    rst_n        = 1'b0;
    #1;
    chk("rst_grant", bus.grant, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cdc_req", bus.cdc_req, 0);
    chk("rst_err", bus.err, 0);
    do_reset();

    // Single transfer with exact handshake timing.
    bus.req = 4'b0100;
    tick();
    chk("single_grant", bus.grant, 4'b0100);
    chk("single_data", bus.cdc_data, 4'hA);
    chk("single_cdc_req", bus.cdc_req, 1);
    chk("single_busy", bus.busy, 1);
    n = 0;
    drop_at = 0;
    while (bus.done == 4'b0 && n < 40) begin
      tick();
      n++;
      if (drop_at == 0 && bus.cdc_req == 1'b0) drop_at = n;
    end
    chk("single_req_drop_cyc", drop_at, 5);
    chk("single_done_cyc", n, 10);
    chk("single_done", bus.done, 4'b0100);
    chk("single_grant_clr", bus.grant, 0);
    bus.req = 4'b0;
    tick();
    chk("single_done_pulse", bus.done, 0);
    chk("single_busy_fall", bus.busy, 0);

    // Fairness from ptr 0.
    do_reset();
    bus.req = 4'b1111;
    wait_grant("fair0", 4'b0001, 4'h3);
    wait_done("fair0", 4'b0001);
    wait_grant("fair1", 4'b0010, 4'h5);
    wait_done("fair1", 4'b0010);
    wait_grant("fair2", 4'b0100, 4'hA);
    wait_done("fair2", 4'b0100);
    wait_grant("fair3", 4'b1000, 4'hC);
    wait_done("fair3", 4'b1000);
    bus.req = 4'b0001;
    wait_grant("fair_wrap", 4'b0001, 4'h3);
    wait_done("fair_wrap", 4'b0001);

    // Hold-off with ptr=1.
    do_reset();
    bus.req = 4'b0001;
    wait_grant("hold_pre", 4'b0001, 4'h3);
    wait_done("hold_pre", 4'b0001);
    tick();
    bus.req = 4'b0011;
    wait_grant("hold_a", 4'b0010, 4'h5);
    wait_done("hold_a", 4'b0010);
    wait_grant("hold_b", 4'b0001, 4'h3);
    bus.req = bus.req | 4'b1000;
    tick();
    tick();
    chk("hold_no_preempt", bus.grant, 4'b0001);
    chk("hold_data_stable", bus.cdc_data, 4'h3);
    wait_done("hold_b", 4'b0001);
    wait_grant("hold_c", 4'b1000, 4'hC);
    wait_done("hold_c", 4'b1000);

    // Stale ack from reset.
    ack_force = 1'b1;
    do_reset();
    tick();
    tick();
    tick();
    bus.req = 4'b0001;
    for (int i = 0; i < 6; i++) tick();
    chk("stale_no_grant", bus.grant, 0);
    chk("stale_idle", bus.busy, 0);
    ack_force = 1'b0;
    tick();
    chk("stale_hold1", bus.grant, 0);
    tick();
    chk("stale_hold2", bus.grant, 0);
    tick();
    chk("stale_grant", bus.grant, 4'b0001);
    wait_done("stale", 4'b0001);

    // Reset mid-REQ re-arbitrates from ptr 0.
    do_reset();
    bus.req = 4'b0010;
    wait_grant("mid_pre", 4'b0010, 4'h5);
    wait_done("mid_pre", 4'b0010);
    tick();
    bus.req = 4'b0101;
    tick();
    chk("mid_grant", bus.grant, 4'b0100);
    chk("mid_cdc_req", bus.cdc_req, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", bus.grant, 0);
    chk("mid_rst_cdc_req", bus.cdc_req, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_data", bus.cdc_data, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rearb", bus.grant, 4'b0001);
    chk("mid_rearb_data", bus.cdc_data, 4'h3);
    wait_done("mid_rearb", 4'b0001);
    bus.req = 4'b0;
    tick();
    chk("mid_no_err", bus.err, 0);

    // Ack never rises.
    do_reset();
    ack_en  = 1'b0;
    bus.req = 4'b1000;
    tick();
    chk("tmo_grant", bus.grant, 4'b1000);
`ifdef CDC_TIMEOUT_EN
    n = 0;
    while (bus.err == 1'b0 && n < 100) begin
      tick();
      n++;
    end
    chk("tmo_cycles", n, 64);
    chk("tmo_err", bus.err, 1);
    chk("tmo_cdc_req", bus.cdc_req, 0);
    chk("tmo_grant_clr", bus.grant, 0);
    chk("tmo_no_done", bus.done, 0);
    bus.req = 4'b0;
    tick();
    chk("tmo_err_pulse", bus.err, 0);
    chk("tmo_idle", bus.busy, 0);
`else
    for (int i = 0; i < 100; i++) tick();
    chk("notmo_busy", bus.busy, 1);
    chk("notmo_err", bus.err, 0);
    chk("notmo_grant", bus.grant, 4'b1000);
    chk("notmo_cdc_req", bus.cdc_req, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
